// File: rtl/debugger_rx_if.sv
// Byte-in / frame-out bundle between the UART receiver, debugger_rx and the debug controller.
// The slave modport is the debugger_rx side; the master modport is the byte source / frame consumer.
interface debugger_rx_if #(
    parameter int FRAME_BYTES = 176
);
    logic                       rx_done;
    logic [7:0]                 rx_data;
    logic [FRAME_BYTES*8-1:0]   frame_data;
    logic                       frame_valid;
    logic                       frame_error;
    logic [1:0]                 err_code;
    logic                       busy;
    logic [1:0]                 state_reg_rx;

    modport master (
        output rx_done, rx_data,
        input  frame_data, frame_valid, frame_error, err_code, busy, state_reg_rx
    );

    modport slave (
        input  rx_done, rx_data,
        output frame_data, frame_valid, frame_error, err_code, busy, state_reg_rx
    );
endinterface

// File: rtl/debugger_rx.sv
// Debug-link receiver: hunts for the sync byte, shifts a fixed-length payload in MSB-first,
// verifies the trailing XOR checksum and publishes good frames with a one-cycle strobe.
module debugger_rx #(
    parameter int          FRAME_BYTES    = 176,
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    debugger_rx_if.slave  bus
);
    localparam int W     = FRAME_BYTES * 8;
    localparam int CNT_W = $clog2(FRAME_BYTES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        RECV  = 2'b00,
        CHECK = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       shift_q, shift_d;
    logic [W-1:0]       frame_data_q, frame_data_d;
    logic [7:0]         csum_q, csum_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               frame_valid_q, frame_valid_d;
    logic               frame_error_q, frame_error_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               busy_q, busy_d;
    logic               expired;

    // Idle counter stops at all-ones instead of wrapping back into a "fresh" count.
    function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
        return (&v) ? v : v + TO_W'(1);
    endfunction

    assign expired = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) && !bus.rx_done;

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        frame_data_d  = frame_data_q;
        csum_d        = csum_q;
        byte_cnt_d    = byte_cnt_q;
        to_cnt_d      = to_cnt_q;
        frame_valid_d = 1'b0;
        frame_error_d = 1'b0;
        err_code_d    = err_code_q;

        unique case (state_q)
            IDLE: begin
                if (bus.rx_done && bus.rx_data == SYNC_BYTE) begin
                    byte_cnt_d = '0;
                    csum_d     = '0;
                    to_cnt_d   = '0;
                    state_d    = RECV;
                end
            end
            RECV: begin
                if (bus.rx_done) begin
                    shift_d    = {shift_q[W-9:0], bus.rx_data};
                    csum_d     = csum_q ^ bus.rx_data;
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    to_cnt_d   = '0;
                    if (byte_cnt_q == CNT_W'(FRAME_BYTES - 1))
                        state_d = CHECK;
                end else if (expired) begin
                    frame_error_d = 1'b1;
                    err_code_d    = 2'b01;
                    state_d       = IDLE;
                end else begin
                    to_cnt_d = sat_inc(to_cnt_q);
                end
            end
            CHECK: begin
                if (bus.rx_done) begin
                    to_cnt_d = '0;
                    if (bus.rx_data == csum_q) begin
                        state_d = DONE;
                    end else begin
                        frame_error_d = 1'b1;
                        err_code_d    = 2'b10;
                        state_d       = IDLE;
                    end
                end else if (expired) begin
                    frame_error_d = 1'b1;
                    err_code_d    = 2'b01;
                    state_d       = IDLE;
                end else begin
                    to_cnt_d = sat_inc(to_cnt_q);
                end
            end
            DONE: begin
                // Publishing here puts frame_data and frame_valid one edge after the checksum edge.
                frame_data_d  = shift_q;
                frame_valid_d = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RECV) || (state_d == CHECK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            frame_data_q  <= '0;
            csum_q        <= '0;
            byte_cnt_q    <= '0;
            to_cnt_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            err_code_q    <= 2'b00;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            frame_data_q  <= frame_data_d;
            csum_q        <= csum_d;
            byte_cnt_q    <= byte_cnt_d;
            to_cnt_q      <= to_cnt_d;
            frame_valid_q <= frame_valid_d;
            frame_error_q <= frame_error_d;
            err_code_q    <= err_code_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.frame_data   = frame_data_q;
    assign bus.frame_valid  = frame_valid_q;
    assign bus.frame_error  = frame_error_q;
    assign bus.err_code     = err_code_q;
    assign bus.busy         = busy_q;
    assign bus.state_reg_rx = state_q;
endmodule

// File: tb/tb_debugger_rx.sv
// Directed bench for debugger_rx with FRAME_BYTES=4, TIMEOUT_CYCLES=20; frame outcomes are
// queued as stimulus is issued and matched against frame_valid / frame_error pulses.
module tb_debugger_rx;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic        is_err;
        logic [1:0]  code;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    debugger_rx_if #(.FRAME_BYTES(4)) bus ();

    debugger_rx #(
        .FRAME_BYTES(4),
        .TIMEOUT_CYCLES(20),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        bus.rx_done = 1'b1;
        bus.rx_data = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.rx_done = 1'b0;
        end
    endtask

    function automatic logic [7:0] xsum(input logic [31:0] p);
        return p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
    endfunction

    task automatic push_good(input logic [31:0] d);
        sb.push_back('{is_err: 1'b0, code: 2'b00, data: d});
    endtask

    task automatic push_err(input logic [1:0] c);
        sb.push_back('{is_err: 1'b1, code: c, data: 32'h0});
    endtask

    // Sends sync + payload + checksum back-to-back.
    task automatic send_frame(input logic [31:0] p, input logic [7:0] cs);
        put(8'hA5);
        for (int i = 3; i >= 0; i--) put(p[i*8 +: 8]);
        put(cs);
    endtask

    // Scoreboard: every strobe must match the oldest queued outcome.
    always @(negedge clk) begin
        if (!reset && (bus.frame_valid || bus.frame_error)) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed valid=%0b error=%0b expected no event",
                       bus.frame_valid, bus.frame_error);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_kind_error", {31'd0, bus.frame_error}, {31'd0, e.is_err});
                check("sb_kind_valid", {31'd0, bus.frame_valid}, {31'd0, !e.is_err});
                if (e.is_err) check("sb_err_code", {30'd0, bus.err_code}, {30'd0, e.code});
                else          check("sb_frame_data", bus.frame_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", {30'd0, bus.state_reg_rx}, 32'h1);
        check("rst_frame_data", bus.frame_data, 32'h0);
        check("rst_valid", {31'd0, bus.frame_valid}, 32'h0);
        check("rst_error", {31'd0, bus.frame_error}, 32'h0);
        check("rst_err_code", {30'd0, bus.err_code}, 32'h0);
        check("rst_busy", {31'd0, bus.busy}, 32'h0);
        reset = 1'b0;
        idle(2);

        // Good frame, 10 cycles between strobes.
        push_good(32'h11223344);
        put(8'hA5); idle(1);
        check("good_busy_after_sync", {31'd0, bus.busy}, 32'h1);
        check("good_state_recv", {30'd0, bus.state_reg_rx}, 32'h0);
        idle(8);
        put(8'h11); idle(9);
        put(8'h22); idle(9);
        put(8'h33); idle(9);
        put(8'h44); idle(1);
        check("good_state_check", {30'd0, bus.state_reg_rx}, 32'h2);
        idle(8);
        put(xsum(32'h11223344)); idle(1);
        check("good_state_done", {30'd0, bus.state_reg_rx}, 32'h3);
        check("good_valid_not_yet", {31'd0, bus.frame_valid}, 32'h0);
        check("good_busy_low_done", {31'd0, bus.busy}, 32'h0);
        idle(1);
        check("good_valid_pulse", {31'd0, bus.frame_valid}, 32'h1);
        check("good_frame_data", bus.frame_data, 32'h11223344);
        check("good_no_error", {31'd0, bus.frame_error}, 32'h0);
        idle(1);
        check("good_valid_one_cycle", {31'd0, bus.frame_valid}, 32'h0);
        check("good_busy_after", {31'd0, bus.busy}, 32'h0);
        idle(3);

        // Bad checksum.
        push_err(2'b10);
        put(8'hA5); put(8'h11); put(8'h22); put(8'h33); put(8'h44); idle(2);
        put(8'h45); idle(1);
        check("badcs_error_pulse", {31'd0, bus.frame_error}, 32'h1);
        check("badcs_err_code", {30'd0, bus.err_code}, 32'h2);
        check("badcs_frame_kept", bus.frame_data, 32'h11223344);
        check("badcs_state_idle", {30'd0, bus.state_reg_rx}, 32'h1);
        idle(3);

        // Timeout: silence after the 22 byte.
        push_err(2'b01);
        put(8'hA5); put(8'h11); put(8'h22);
        idle(20);
        check("to_no_error_early", {31'd0, bus.frame_error}, 32'h0);
        check("to_busy_waiting", {31'd0, bus.busy}, 32'h1);
        idle(1);
        check("to_error_pulse", {31'd0, bus.frame_error}, 32'h1);
        check("to_err_code", {30'd0, bus.err_code}, 32'h1);
        check("to_state_idle", {30'd0, bus.state_reg_rx}, 32'h1);
        idle(3);

        // A byte sampled on the expiry edge is still accepted.
        push_good(32'h11223344);
        put(8'hA5); put(8'h11); put(8'h22);
        idle(19);
        put(8'h33); idle(1);
        check("coinc_no_error", {31'd0, bus.frame_error}, 32'h0);
        check("coinc_busy", {31'd0, bus.busy}, 32'h1);
        put(8'h44); put(xsum(32'h11223344)); idle(3);
        check("coinc_frame_data", bus.frame_data, 32'h11223344);

        // Garbage before sync, sync value inside payload (payload XOR is 00).
        put(8'h00); idle(2); put(8'hFF); idle(2); put(8'h5A); idle(2);
        check("garbage_state_idle", {30'd0, bus.state_reg_rx}, 32'h1);
        check("garbage_busy", {31'd0, bus.busy}, 32'h0);
        push_good(32'hA5A5A5A5);
        send_frame(32'hA5A5A5A5, xsum(32'hA5A5A5A5)); idle(3);
        check("insync_frame_data", bus.frame_data, 32'hA5A5A5A5);

        // Back-to-back frames; a sync arriving in DONE must be dropped.
        push_good(32'h01020304);
        push_good(32'hDEADBEEF);
        send_frame(32'h01020304, xsum(32'h01020304));
        put(8'hA5);
        send_frame(32'hDEADBEEF, xsum(32'hDEADBEEF));
        idle(3);
        check("b2b_frame_data", bus.frame_data, 32'hDEADBEEF);

        // Asynchronous reset mid-frame.
        put(8'hA5); put(8'h11); idle(1);
        #2 reset = 1'b1;
        #1;
        check("midrst_state", {30'd0, bus.state_reg_rx}, 32'h1);
        check("midrst_frame_data", bus.frame_data, 32'h0);
        check("midrst_err_code", {30'd0, bus.err_code}, 32'h0);
        check("midrst_busy", {31'd0, bus.busy}, 32'h0);
        idle(2);
        reset = 1'b0;
        idle(1);
        push_good(32'h55667788);
        send_frame(32'h55667788, xsum(32'h55667788)); idle(3);
        check("postrst_frame_data", bus.frame_data, 32'h55667788);

        idle(2);
        check("sb_drained", sb.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
